// File: rtl/lcd_frame_capture.sv
// lcd_frame_capture
//   Captures the SM510 LCD strobe outputs into a 4-phase frame. Each H phase
//   (lcd_h = 1/2/4/8) is sampled once after a settle delay. A complete frame
//   is committed to the display buffer in a single edge. The renderer reads
//   the display buffer through a request/valid port.
//
// Ports
//   clk, reset_n      system clock, async active-low reset
//   clk_en            32.768kHz tick; the capture FSM only advances on it
//   lcd_h             H strobe from the core, one-hot when valid
//   segment_a/_b/_bs  segment words for the current H
//   lcd_bc            bleeder; 1 = display off, blanks the committed frame
//   rd_req, rd_h      read request and phase index (every clk)
//   rd_valid, rd_data one-clk response, {bs, b, a} of the committed frame
//   frame_done        one-clk pulse on commit
//   frame_valid       sticky, set by the first commit
//   seq_error         one-clk pulse when the H order is broken
module lcd_frame_capture #(
   parameter int unsigned SETTLE_TICKS = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clk_en,
   input  logic [3:0]  lcd_h,
   input  logic [15:0] segment_a,
   input  logic [15:0] segment_b,
   input  logic        segment_bs,
   input  logic        lcd_bc,
   input  logic        rd_req,
   input  logic [1:0]  rd_h,
   output logic        rd_valid,
   output logic [32:0] rd_data,
   output logic        frame_done,
   output logic        frame_valid,
   output logic        seq_error
);

   // state       | meaning
   // WAIT_H1     | idle, waiting for the H1 strobe that opens a frame
   // SETTLE      | counting down after an H edge; lcd_h must hold
   // CAPTURE     | sample one phase into the working buffer (one tick)
   // WAIT_CHANGE | phase captured, waiting for the next H strobe
   typedef enum logic [1:0] {
      WAIT_H1,
      SETTLE,
      CAPTURE,
      WAIT_CHANGE
   } state_t;

   localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_TICKS - 1);

   state_t           state_q, state_d, settle_entry;
   logic [7:0]       cnt_q, cnt_d;
   logic [1:0]       phase_q, phase_d;
   logic             blank_q, blank_d;
   logic [3:0][32:0] working_q, working_d;
   logic [3:0][32:0] display_q;
   logic [3:0]       h_exp, h_nxt;
   logic [32:0]      wr_word;
   logic             commit, seq_err;

   logic             rd_valid_q;
   logic [32:0]      rd_data_q;
   logic             frame_done_q, frame_valid_q, seq_error_q;

   assign h_exp   = 4'b0001 << phase_q;
   assign h_nxt   = 4'b0001 << (phase_q + 2'd1);
   assign wr_word = {segment_bs, segment_b, segment_a};

   // The tick that sees the H edge counts as the first settle tick, so the
   // sample lands SETTLE_TICKS ticks after the edge; with 1 there is nothing
   // left to count and the next tick samples directly.
   assign settle_entry = (SETTLE_TICKS == 1) ? CAPTURE : SETTLE;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      phase_d   = phase_q;
      blank_d   = blank_q;
      working_d = working_q;
      commit    = 1'b0;
      seq_err   = 1'b0;

      if (clk_en) begin
         unique case (state_q)
            WAIT_H1: begin
               if (lcd_h == 4'b0001) begin
                  cnt_d   = SETTLE_LOAD;
                  phase_d = 2'd0;
                  blank_d = 1'b0;
                  state_d = settle_entry;
               end
            end
            SETTLE: begin
               if (lcd_h != h_exp) begin
                  seq_err = 1'b1;
               end else begin
                  if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
                  if (cnt_q <= 8'd1) state_d = CAPTURE;
               end
            end
            CAPTURE: begin
               if (lcd_h != h_exp) begin
                  seq_err = 1'b1;
               end else begin
                  working_d[phase_q] = wr_word;
                  blank_d            = blank_q | lcd_bc;
                  if (phase_q == 2'd3) begin
                     commit  = 1'b1;
                     state_d = WAIT_H1;
                  end else begin
                     state_d = WAIT_CHANGE;
                  end
               end
            end
            WAIT_CHANGE: begin
               if (lcd_h != h_exp) begin
                  if (lcd_h == h_nxt) begin
                     phase_d = phase_q + 2'd1;
                     cnt_d   = SETTLE_LOAD;
                     state_d = settle_entry;
                  end else begin
                     seq_err = 1'b1;
                  end
               end
            end
         endcase

         // A broken sequence throws away the partial frame; the display
         // buffer keeps the last good frame.
         if (seq_err) begin
            state_d   = WAIT_H1;
            cnt_d     = 8'd0;
            phase_d   = 2'd0;
            blank_d   = 1'b0;
            working_d = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= WAIT_H1;
         cnt_q         <= 8'd0;
         phase_q       <= 2'd0;
         blank_q       <= 1'b0;
         working_q     <= '0;
         display_q     <= '0;
         rd_valid_q    <= 1'b0;
         rd_data_q     <= '0;
         frame_done_q  <= 1'b0;
         frame_valid_q <= 1'b0;
         seq_error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         phase_q   <= phase_d;
         blank_q   <= blank_d;
         working_q <= working_d;

         // blank_d already folds in lcd_bc from the H8 capture tick.
         if (commit) display_q <= blank_d ? '0 : working_d;

         // Reads see display_q before this edge's commit.
         rd_valid_q <= rd_req;
         if (rd_req) rd_data_q <= frame_valid_q ? display_q[rd_h] : '0;

         frame_done_q  <= commit;
         frame_valid_q <= frame_valid_q | commit;
         seq_error_q   <= seq_err;
      end
   end

   assign rd_valid    = rd_valid_q;
   assign rd_data     = rd_data_q;
   assign frame_done  = frame_done_q;
   assign frame_valid = frame_valid_q;
   assign seq_error   = seq_error_q;

endmodule

// File: tb/tb_lcd_frame_capture.sv
module tb_lcd_frame_capture;

   localparam int unsigned SETTLE = 4;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        clk_en;
   logic [3:0]  lcd_h;
   logic [15:0] segment_a, segment_b;
   logic        segment_bs, lcd_bc;
   logic        rd_req;
   logic [1:0]  rd_h;
   logic        rd_valid;
   logic [32:0] rd_data;
   logic        frame_done, frame_valid, seq_error;

   bit          clk_run = 1'b1;
   int          checks = 0;
   int          errors = 0;
   int          tick_no = 0;
   int          fd_cnt = 0;
   int          se_cnt = 0;
   int          fd_tick = -1;
   logic        req_d = 1'b0;
   logic [32:0] mon_e;
   logic [32:0] exp_q[$];
   logic [32:0] exp_disp [4];
   logic [32:0] mw [4];
   logic        mbl;

   typedef struct {
      logic [3:0]  h;
      logic [32:0] w;
      logic        bc;
      int          n;
      bit          exp_done;
      bit          exp_err;
      bit          rd_after;
   } step_t;

   step_t steps[$];

   lcd_frame_capture #(.SETTLE_TICKS(SETTLE)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .clk_en      (clk_en),
      .lcd_h       (lcd_h),
      .segment_a   (segment_a),
      .segment_b   (segment_b),
      .segment_bs  (segment_bs),
      .lcd_bc      (lcd_bc),
      .rd_req      (rd_req),
      .rd_h        (rd_h),
      .rd_valid    (rd_valid),
      .rd_data     (rd_data),
      .frame_done  (frame_done),
      .frame_valid (frame_valid),
      .seq_error   (seq_error)
   );

   initial forever #5 if (clk_run) clk = ~clk;

   task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %h, required %h", name, act, exp);
      end
   endtask

   // Read scoreboard: every request pushes its expected word; the response
   // one clk later pops and compares.
   always @(posedge clk) req_d <= rd_req;

   always @(negedge clk) begin
      if (frame_done) begin
         fd_cnt++;
         fd_tick = tick_no;
      end
      if (seq_error) se_cnt++;
      if (req_d) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rd_scoreboard: response with no expected entry, rd_data %h", rd_data);
         end else begin
            mon_e = exp_q.pop_front();
            chk("rd_valid", 33'(rd_valid), 33'd1);
            chk("rd_data", rd_data, mon_e);
         end
      end else begin
         chk("rd_valid_idle", 33'(rd_valid), 33'd0);
      end
   end

   task automatic tick();
      tick_no++;
      clk_en = 1'b1;
      @(negedge clk);
      clk_en = 1'b0;
      @(negedge clk);
   endtask

   task automatic phase(input logic [3:0] h, input logic [32:0] w, input logic bc, input int n);
      lcd_h      = h;
      segment_bs = w[32];
      segment_b  = w[31:16];
      segment_a  = w[15:0];
      lcd_bc     = bc;
      repeat (n) tick();
   endtask

   task automatic rd_one(input logic [1:0] h, input logic [32:0] e);
      rd_req = 1'b1;
      rd_h   = h;
      exp_q.push_back(e);
      @(negedge clk);
      rd_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic read_all();
      for (int p = 0; p < 4; p++) begin
         rd_req = 1'b1;
         rd_h   = 2'(p);
         exp_q.push_back(exp_disp[p]);
         @(negedge clk);
      end
      rd_req = 1'b0;
      @(negedge clk);
   endtask

   function automatic step_t mk(input logic [3:0] h, input logic [32:0] w, input logic bc,
                                input int n, input bit d, input bit e, input bit r);
      step_t s;
      s.h = h; s.w = w; s.bc = bc; s.n = n;
      s.exp_done = d; s.exp_err = e; s.rd_after = r;
      return s;
   endfunction

   function automatic int hot_idx(input logic [3:0] h);
      case (h)
         4'b0001: return 0;
         4'b0010: return 1;
         4'b0100: return 2;
         4'b1000: return 3;
         default: return -1;
      endcase
   endfunction

   initial begin
      step_t       st;
      int          fd0, se0, t0, idx;
      logic [32:0] new_f [4];

      // Frame A: clean, a = 1111*phase, b = A5A5, bs = phase[0]
      steps.push_back(mk(4'b0001, {1'b0, 16'hA5A5, 16'h0000}, 1'b0, 20, 0, 0, 0));
      steps.push_back(mk(4'b0010, {1'b1, 16'hA5A5, 16'h1111}, 1'b0, 20, 0, 0, 0));
      steps.push_back(mk(4'b0100, {1'b0, 16'hA5A5, 16'h2222}, 1'b0, 20, 0, 0, 0));
      steps.push_back(mk(4'b1000, {1'b1, 16'hA5A5, 16'h3333}, 1'b0, 20, 1, 0, 1));
      // Frame B: H1, H2, then H8 skipping H4
      steps.push_back(mk(4'b0001, {1'b1, 16'h5555, 16'hAAAA}, 1'b0, 10, 0, 0, 0));
      steps.push_back(mk(4'b0010, {1'b1, 16'h5555, 16'hBBBB}, 1'b0, 10, 0, 0, 0));
      steps.push_back(mk(4'b1000, {1'b1, 16'h5555, 16'hCCCC}, 1'b0,  6, 0, 1, 1));
      // Frame C: clean recovery
      steps.push_back(mk(4'b0001, {1'b1, 16'h8001, 16'h1234}, 1'b0, 10, 0, 0, 0));
      steps.push_back(mk(4'b0010, {1'b0, 16'h4002, 16'h5678}, 1'b0, 10, 0, 0, 0));
      steps.push_back(mk(4'b0100, {1'b1, 16'h2004, 16'h9ABC}, 1'b0, 10, 0, 0, 0));
      steps.push_back(mk(4'b1000, {1'b0, 16'h1008, 16'hDEF0}, 1'b0, 10, 1, 0, 1));
      // Frame D: H changes while still settling
      steps.push_back(mk(4'b0001, {1'b1, 16'h7777, 16'h7777}, 1'b0,  2, 0, 0, 0));
      steps.push_back(mk(4'b0010, {1'b1, 16'h7777, 16'h7777}, 1'b0,  6, 0, 1, 1));
      // Frame E: bleeder on during H4 blanks the whole frame
      steps.push_back(mk(4'b0001, {1'b1, 16'hFACE, 16'h0001}, 1'b0, 10, 0, 0, 0));
      steps.push_back(mk(4'b0010, {1'b1, 16'hFACE, 16'h0002}, 1'b0, 10, 0, 0, 0));
      steps.push_back(mk(4'b0100, {1'b1, 16'hFACE, 16'h0003}, 1'b1, 10, 0, 0, 0));
      steps.push_back(mk(4'b1000, {1'b1, 16'hFACE, 16'h0004}, 1'b0, 10, 1, 0, 1));
      // Frame F: non-one-hot strobe; Frame G: strobe drops to zero
      steps.push_back(mk(4'b0001, {1'b0, 16'h0F0F, 16'hF0F0}, 1'b0, 10, 0, 0, 0));
      steps.push_back(mk(4'b0011, {1'b0, 16'h0F0F, 16'hF0F0}, 1'b0,  6, 0, 1, 0));
      steps.push_back(mk(4'b0001, {1'b0, 16'h0F0F, 16'hF0F0}, 1'b0, 10, 0, 0, 0));
      steps.push_back(mk(4'b0000, {1'b0, 16'h0F0F, 16'hF0F0}, 1'b0,  6, 0, 1, 1));
      // Frame H: clean, all-ones word in one phase
      steps.push_back(mk(4'b0001, {1'b1, 16'hFFFF, 16'hFFFF}, 1'b0, 10, 0, 0, 0));
      steps.push_back(mk(4'b0010, {1'b0, 16'h0000, 16'h0001}, 1'b0, 10, 0, 0, 0));
      steps.push_back(mk(4'b0100, {1'b1, 16'h8000, 16'h0000}, 1'b0, 10, 0, 0, 0));
      steps.push_back(mk(4'b1000, {1'b0, 16'h1357, 16'h2468}, 1'b0, 10, 1, 0, 1));

      clk_en = 1'b0; lcd_h = 4'h0; segment_a = '0; segment_b = '0;
      segment_bs = 1'b0; lcd_bc = 1'b0; rd_req = 1'b0; rd_h = 2'd0;
      for (int p = 0; p < 4; p++) begin exp_disp[p] = '0; mw[p] = '0; end
      mbl = 1'b0;

      repeat (3) @(negedge clk);
      chk("reset rd_valid",    33'(rd_valid),    33'd0);
      chk("reset rd_data",     rd_data,          33'd0);
      chk("reset frame_done",  33'(frame_done),  33'd0);
      chk("reset frame_valid", 33'(frame_valid), 33'd0);
      chk("reset seq_error",   33'(seq_error),   33'd0);
      reset_n = 1'b1;
      @(negedge clk);
      read_all();

      for (int i = 0; i < steps.size(); i++) begin
         st  = steps[i];
         fd0 = fd_cnt;
         se0 = se_cnt;
         t0  = tick_no;
         idx = hot_idx(st.h);
         if (st.h == 4'b0001) mbl = 1'b0;
         if (idx >= 0) begin
            mw[idx] = st.w;
            mbl     = mbl | st.bc;
         end
         phase(st.h, st.w, st.bc, st.n);
         chk($sformatf("step%0d frame_done count", i), 33'(fd_cnt - fd0), 33'(st.exp_done));
         chk($sformatf("step%0d seq_error count", i),  33'(se_cnt - se0), 33'(st.exp_err));
         if (st.exp_done) begin
            // First tick seeing H8 is the edge; the commit lands SETTLE ticks later.
            chk($sformatf("step%0d commit tick", i), 33'(fd_tick), 33'(t0 + 1 + int'(SETTLE)));
            chk($sformatf("step%0d frame_valid", i), 33'(frame_valid), 33'd1);
            for (int p = 0; p < 4; p++) exp_disp[p] = mbl ? 33'd0 : mw[p];
         end
         if (st.exp_done || st.exp_err) begin
            for (int p = 0; p < 4; p++) mw[p] = '0;
            mbl = 1'b0;
         end
         if (st.rd_after) read_all();
         if (i == 3) rd_one(2'd2, {1'b0, 16'hA5A5, 16'h2222});
      end

      // Settle timing: segment_a changes 2 ticks into H1; only the new value may land.
      fd0 = fd_cnt;
      phase(4'b0001, {1'b0, 16'h1357, 16'hDEAD}, 1'b0, 2);
      segment_a = 16'hBEEF;
      repeat (18) tick();
      phase(4'b0010, {1'b1, 16'h0002, 16'h0020}, 1'b0, 10);
      phase(4'b0100, {1'b0, 16'h0004, 16'h0040}, 1'b0, 10);
      phase(4'b1000, {1'b1, 16'h0008, 16'h0080}, 1'b0, 10);
      chk("settle frame_done count", 33'(fd_cnt - fd0), 33'd1);
      exp_disp[0] = {1'b0, 16'h1357, 16'hBEEF};
      exp_disp[1] = {1'b1, 16'h0002, 16'h0020};
      exp_disp[2] = {1'b0, 16'h0004, 16'h0040};
      exp_disp[3] = {1'b1, 16'h0008, 16'h0080};
      read_all();

      // Read on the commit edge returns the old frame; one clk later the new one.
      new_f[0] = {1'b1, 16'hC001, 16'h0101};
      new_f[1] = {1'b0, 16'hC002, 16'h0202};
      new_f[2] = {1'b1, 16'hC004, 16'h0404};
      new_f[3] = {1'b0, 16'hC008, 16'h0808};
      fd0 = fd_cnt;
      phase(4'b0001, new_f[0], 1'b0, 20);
      phase(4'b0010, new_f[1], 1'b0, 20);
      phase(4'b0100, new_f[2], 1'b0, 20);
      t0 = tick_no;
      phase(4'b1000, new_f[3], 1'b0, SETTLE);
      chk("collision no early commit", 33'(fd_cnt - fd0), 33'd0);
      tick_no++;
      clk_en = 1'b1;
      rd_req = 1'b1;
      rd_h   = 2'd1;
      exp_q.push_back(exp_disp[1]);
      @(negedge clk);
      clk_en = 1'b0;
      exp_q.push_back(new_f[1]);
      @(negedge clk);
      rd_req = 1'b0;
      @(negedge clk);
      chk("collision frame_done count", 33'(fd_cnt - fd0), 33'd1);
      chk("collision commit tick", 33'(fd_tick), 33'(t0 + 1 + int'(SETTLE)));
      for (int p = 0; p < 4; p++) exp_disp[p] = new_f[p];
      read_all();

      // Reset mid-frame with the clock stopped.
      phase(4'b0001, {1'b1, 16'h9999, 16'h9999}, 1'b0, 20);
      phase(4'b0010, {1'b1, 16'h8888, 16'h8888}, 1'b0, 20);
      rd_one(2'd3, exp_disp[3]);
      chk("pre-reset frame_valid", 33'(frame_valid), 33'd1);
      clk_run = 1'b0;
      #20;
      reset_n = 1'b0;
      #2;
      chk("async reset rd_valid",    33'(rd_valid),    33'd0);
      chk("async reset rd_data",     rd_data,          33'd0);
      chk("async reset frame_done",  33'(frame_done),  33'd0);
      chk("async reset frame_valid", 33'(frame_valid), 33'd0);
      chk("async reset seq_error",   33'(seq_error),   33'd0);
      #11;
      reset_n = 1'b1;
      #4;
      clk_run = 1'b1;
      @(negedge clk);
      for (int p = 0; p < 4; p++) exp_disp[p] = '0;
      read_all();
      fd0 = fd_cnt;
      se0 = se_cnt;
      phase(4'b0001, {1'b0, 16'h4444, 16'h1010}, 1'b0, 10);
      phase(4'b0010, {1'b1, 16'h4444, 16'h2020}, 1'b0, 10);
      phase(4'b0100, {1'b0, 16'h4444, 16'h4040}, 1'b0, 10);
      phase(4'b1000, {1'b1, 16'h4444, 16'h8080}, 1'b0, 10);
      chk("post-reset frame_done count", 33'(fd_cnt - fd0), 33'd1);
      chk("post-reset seq_error count",  33'(se_cnt - se0), 33'd0);
      chk("post-reset frame_valid",      33'(frame_valid),  33'd1);
      exp_disp[0] = {1'b0, 16'h4444, 16'h1010};
      exp_disp[1] = {1'b1, 16'h4444, 16'h2020};
      exp_disp[2] = {1'b0, 16'h4444, 16'h4040};
      exp_disp[3] = {1'b1, 16'h4444, 16'h8080};
      read_all();

      chk("scoreboard drained", 33'(exp_q.size()), 33'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
